// File: rtl/mem_access_ctrl.sv
// Load/store bus sequencer: latches one memory-stage request, runs a single
// data-bus transaction through the byte-lane units and returns the aligned result.

package mem_access_pkg;
    typedef enum logic [3:0] {
        LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
    } instruction_type;

    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

    function automatic msize_t op_size(input instruction_type op);
        case (op)
            LH, LHU, SH: op_size = MSIZE2;
            LW, LWU, SW: op_size = MSIZE4;
            LD, SD:      op_size = MSIZE8;
            default:     op_size = MSIZE1;
        endcase
    endfunction

    function automatic logic is_store(input instruction_type op);
        is_store = (op == SB) || (op == SH) || (op == SW) || (op == SD);
    endfunction
endpackage

// Request side: access size, lane strobe and lane-shifted store data.
module databus_pre_align
    import mem_access_pkg::*;
(
    input  instruction_type op,
    input  logic [2:0]      offset,
    input  logic [63:0]     wdata,
    output msize_t          size,
    output logic [7:0]      strobe,
    output logic [63:0]     data
);
    logic [7:0] base_strobe;

    always_comb begin
        size = op_size(op);
        case (size)
            MSIZE2:  base_strobe = 8'h03;
            MSIZE4:  base_strobe = 8'h0F;
            MSIZE8:  base_strobe = 8'hFF;
            default: base_strobe = 8'h01;
        endcase
        strobe = is_store(op) ? (base_strobe << offset) : 8'h00;
        data   = wdata << {offset, 3'b000};
    end
endmodule

// Response side: pick the addressed lanes out of the read word and extend.
module databus_post_align
    import mem_access_pkg::*;
(
    input  instruction_type op,
    input  logic [2:0]      offset,
    input  logic [63:0]     rdata,
    output logic [63:0]     result
);
    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (op)
            LB:      result = {{56{shifted[7]}}, shifted[7:0]};
            LH:      result = {{48{shifted[15]}}, shifted[15:0]};
            LW:      result = {{32{shifted[31]}}, shifted[31:0]};
            LD:      result = shifted;
            LBU:     result = {56'd0, shifted[7:0]};
            LHU:     result = {48'd0, shifted[15:0]};
            LWU:     result = {32'd0, shifted[31:0]};
            default: result = 64'd0;
        endcase
    end
endmodule

module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int MISALIGN_CHECK = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  instruction_type req_op,
    input  logic [63:0]     req_addr,
    input  logic [63:0]     req_wdata,
    output logic            dreq_valid,
    output logic [63:0]     dreq_addr,
    output msize_t          dreq_size,
    output logic [7:0]      dreq_strobe,
    output logic [63:0]     dreq_data,
    input  logic            dresp_addr_ok,
    input  logic            dresp_data_ok,
    input  logic [63:0]     dresp_data,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [63:0]     resp_rdata,
    output logic            resp_misaligned,
    input  logic            flush
);
    // Handshakes: req transfers when req_valid && req_ready; resp transfers when
    // resp_valid && resp_ready; the bus request holds until dresp_data_ok.
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e          state_q, state_d;
    instruction_type op_q, op_d;
    logic [63:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic            kill_q, kill_d, mis_q, mis_d;
    logic [63:0]     load_result;
    logic [2:0]      req_mask;
    logic            unused_addr_ok;

    assign unused_addr_ok = dresp_addr_ok;

    databus_pre_align u_pre (
        .op     (op_q),
        .offset (addr_q[2:0]),
        .wdata  (wdata_q),
        .size   (dreq_size),
        .strobe (dreq_strobe),
        .data   (dreq_data)
    );

    databus_post_align u_post (
        .op     (op_q),
        .offset (addr_q[2:0]),
        .rdata  (dresp_data),
        .result (load_result)
    );

    always_comb begin
        case (op_size(req_op))
            MSIZE2:  req_mask = 3'b001;
            MSIZE4:  req_mask = 3'b011;
            MSIZE8:  req_mask = 3'b111;
            default: req_mask = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= LB;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            kill_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            kill_q  <= kill_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        kill_d  = kill_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 64'd0;
                    kill_d  = 1'b0;
                    if (MISALIGN_CHECK != 0 && (req_addr[2:0] & req_mask) != 3'b000) begin
                        mis_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        mis_d   = 1'b0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // A flushed transaction still runs to completion on the bus.
                if (flush) kill_d = 1'b1;
                if (dresp_data_ok) begin
                    kill_d = 1'b0;
                    if (kill_q || flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                        rdata_d = load_result;
                    end
                end
            end
            DONE: begin
                if (flush || resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready       = (state_q == IDLE);
    assign dreq_valid      = (state_q == BUSY);
    assign dreq_addr       = addr_q;
    assign resp_valid      = (state_q == DONE) && !flush;
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: expected responses are queued at issue
// and compared when the controller presents them.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid, req_valid2;
  logic            req_ready, req_ready2;
  instruction_type req_op;
  logic [63:0]     req_addr, req_wdata;
  logic            dreq_valid, dreq_valid2;
  logic [63:0]     dreq_addr, dreq_addr2;
  msize_t          dreq_size, dreq_size2;
  logic [7:0]      dreq_strobe, dreq_strobe2;
  logic [63:0]     dreq_data, dreq_data2;
  logic            dresp_addr_ok, dresp_data_ok, dresp_data_ok2;
  logic [63:0]     dresp_data;
  logic            resp_valid, resp_valid2;
  logic            resp_ready, resp_ready2;
  logic [63:0]     resp_rdata, resp_rdata2;
  logic            resp_misaligned, resp_misaligned2;
  logic            flush;

  int errors = 0;
  int checks = 0;
  logic [64:0] exp_q[$];  // {misaligned, rdata}

  // clock / reset
  always #5 clk = ~clk;

  mem_access_ctrl #(.MISALIGN_CHECK(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .flush(flush)
  );

  mem_access_ctrl #(.MISALIGN_CHECK(0)) dut_nocheck (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .dreq_valid(dreq_valid2), .dreq_addr(dreq_addr2), .dreq_size(dreq_size2),
    .dreq_strobe(dreq_strobe2), .dreq_data(dreq_data2),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok2), .dresp_data(dresp_data),
    .resp_valid(resp_valid2), .resp_ready(resp_ready2), .resp_rdata(resp_rdata2),
    .resp_misaligned(resp_misaligned2), .flush(flush)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input instruction_type op,
                       input logic [63:0] addr, input logic [63:0] wdata);
    req_op = op;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    check({tag, " req_ready"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic bus_complete(input logic [63:0] data);
    dresp_data = data;
    dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    dresp_data = 64'(~data);
  endtask

  // scoreboard: wait bounded for resp_valid, compare against queue head, consume
  task automatic take_resp(input string tag, input int budget);
    int n = 0;
    logic [64:0] exp;
    while (resp_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
    if (resp_valid === 1'b1) begin
      check({tag, " queue_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check({tag, " resp_rdata"}, resp_rdata, exp[63:0]);
        check({tag, " resp_misaligned"}, 64'(resp_misaligned), 64'(exp[64]));
      end
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, " idle_after"}, 64'({req_ready, resp_valid}), 64'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rnd;
    reset = 1'b0;
    req_valid = 1'b0; req_valid2 = 1'b0;
    req_op = LB; req_addr = '0; req_wdata = '0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data_ok2 = 1'b0;
    dresp_data = '0; resp_ready = 1'b0; resp_ready2 = 1'b0; flush = 1'b0;

    // reset state
    tick();
    check("rst req_ready", 64'(req_ready), 64'd1);
    check("rst dreq_valid", 64'(dreq_valid), 64'd0);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst resp_rdata", resp_rdata, 64'd0);
    check("rst resp_misaligned", 64'(resp_misaligned), 64'd0);
    check("rst dreq_strobe", 64'(dreq_strobe), 64'd0);
    check("rst dreq_addr", dreq_addr, 64'd0);
    check("rst dreq_data", dreq_data, 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // LB at 0x1003, data_ok 3 cycles after accept
    exp_q.push_back({1'b0, 64'hFFFF_FFFF_FFFF_FF80});
    issue("lb", LB, 64'h1003, 64'h0);
    check("lb c1 dreq_valid", 64'(dreq_valid), 64'd1);
    check("lb c1 dreq_size", 64'(dreq_size), 64'(MSIZE1));
    check("lb c1 dreq_strobe", 64'(dreq_strobe), 64'h00);
    check("lb c1 dreq_addr", dreq_addr, 64'h1003);
    check("lb c1 req_ready", 64'(req_ready), 64'd0);
    tick();
    check("lb c2 dreq_valid", 64'(dreq_valid), 64'd1);
    tick();
    bus_complete(64'h0000_0000_80FF_0000);
    check("lb c4 dreq_valid", 64'(dreq_valid), 64'd0);
    check("lb c4 resp_valid", 64'(resp_valid), 64'd1);
    take_resp("lb", 0);

    // SH at 0x2006 with two stall cycles; addr_ok alone must not release
    exp_q.push_back({1'b0, 64'd0});
    issue("sh", SH, 64'h2006, 64'hBEEF);
    dresp_addr_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("sh stall dreq_valid", 64'(dreq_valid), 64'd1);
      check("sh stall dreq_strobe", 64'(dreq_strobe), 64'hC0);
      check("sh stall dreq_data", dreq_data, 64'hBEEF_0000_0000_0000);
      check("sh stall dreq_size", 64'(dreq_size), 64'(MSIZE2));
      tick();
      dresp_addr_ok = 1'b0;
    end
    rnd = {$urandom(), $urandom()};
    bus_complete(rnd);
    take_resp("sh", 0);

    // SW at 0x2004, addr_ok and data_ok together the cycle dreq_valid rises
    exp_q.push_back({1'b0, 64'd0});
    issue("sw", SW, 64'h2004, 64'h1234_5678);
    check("sw dreq_strobe", 64'(dreq_strobe), 64'hF0);
    check("sw dreq_data", dreq_data, 64'h1234_5678_0000_0000);
    dresp_addr_ok = 1'b1;
    bus_complete(64'hFFFF_FFFF_FFFF_FFFF);
    dresp_addr_ok = 1'b0;
    check("sw c2 resp_valid", 64'(resp_valid), 64'd1);
    take_resp("sw", 0);

    // misaligned LW at 0x3002: trapped, bus untouched
    exp_q.push_back({1'b1, 64'd0});
    issue("lw_mis", LW, 64'h3002, 64'h0);
    check("lw_mis c1 resp_valid", 64'(resp_valid), 64'd1);
    check("lw_mis c1 dreq_valid", 64'(dreq_valid), 64'd0);
    take_resp("lw_mis", 0);
    check("lw_mis after dreq_valid", 64'(dreq_valid), 64'd0);

    // misaligned LD at 0x5004
    exp_q.push_back({1'b1, 64'd0});
    issue("ld_mis", LD, 64'h5004, 64'h0);
    check("ld_mis dreq_valid", 64'(dreq_valid), 64'd0);
    take_resp("ld_mis", 2);

    // same LW with checking disabled reaches the bus
    req_op = LW; req_addr = 64'h3002; req_wdata = '0; req_valid2 = 1'b1;
    tick();
    req_valid2 = 1'b0;
    check("lw_nochk dreq_valid", 64'(dreq_valid2), 64'd1);
    check("lw_nochk dreq_size", 64'(dreq_size2), 64'(MSIZE4));
    check("lw_nochk main idle", 64'(dreq_valid), 64'd0);
    dresp_data = 64'h0000_8765_4321_0000;
    dresp_data_ok2 = 1'b1;
    tick();
    dresp_data_ok2 = 1'b0;
    check("lw_nochk resp_valid", 64'(resp_valid2), 64'd1);
    check("lw_nochk resp_rdata", resp_rdata2, 64'hFFFF_FFFF_8765_4321);
    check("lw_nochk resp_misaligned", 64'(resp_misaligned2), 64'd0);
    resp_ready2 = 1'b1;
    tick();
    resp_ready2 = 1'b0;
    check("lw_nochk req_ready", 64'(req_ready2), 64'd1);

    // LWU at 0x4004 with resp_ready held low for 3 cycles
    exp_q.push_back({1'b0, 64'h0000_0000_8000_0001});
    issue("lwu", LWU, 64'h4004, 64'h0);
    bus_complete(64'h8000_0001_DEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      dresp_data = {$urandom(), $urandom()};
      check("lwu hold resp_valid", 64'(resp_valid), 64'd1);
      check("lwu hold resp_rdata", resp_rdata, 64'h0000_0000_8000_0001);
      check("lwu hold req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    take_resp("lwu", 0);

    // SD at 0x6008: full-width strobe
    rnd = {$urandom(), $urandom()};
    exp_q.push_back({1'b0, 64'd0});
    issue("sd", SD, 64'h6008, rnd);
    check("sd dreq_strobe", 64'(dreq_strobe), 64'hFF);
    check("sd dreq_data", dreq_data, rnd);
    bus_complete(64'h0);
    take_resp("sd", 1);

    // LD flushed one cycle into BUSY, data_ok two cycles later
    issue("ld_flush", LD, 64'h7000, 64'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ld_flush c2 dreq_valid", 64'(dreq_valid), 64'd1);
    check("ld_flush c2 resp_valid", 64'(resp_valid), 64'd0);
    tick();
    check("ld_flush c3 dreq_valid", 64'(dreq_valid), 64'd1);
    bus_complete(64'h1111_2222_3333_4444);
    check("ld_flush c4 dreq_valid", 64'(dreq_valid), 64'd0);
    check("ld_flush c4 resp_valid", 64'(resp_valid), 64'd0);
    check("ld_flush c4 req_ready", 64'(req_ready), 64'd1);
    tick();
    check("ld_flush c5 resp_valid", 64'(resp_valid), 64'd0);

    // flush in the same cycle as data_ok
    issue("lb_flush_ok", LB, 64'h7001, 64'h0);
    flush = 1'b1;
    bus_complete(64'hFF);
    flush = 1'b0;
    check("lb_flush_ok resp_valid", 64'(resp_valid), 64'd0);
    check("lb_flush_ok req_ready", 64'(req_ready), 64'd1);

    // flush in IDLE ignores a same-cycle request
    flush = 1'b1;
    req_op = LD; req_addr = 64'h7008; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check("idle_flush dreq_valid", 64'(dreq_valid), 64'd0);
    check("idle_flush req_ready", 64'(req_ready), 64'd1);

    // queue cleared by the flushed work, then a normal load still works
    exp_q.push_back({1'b0, 64'h0000_0000_0000_00AB});
    issue("lbu", LBU, 64'h7005, 64'h0);
    bus_complete(64'h0000_AB00_0000_0000);
    take_resp("lbu", 0);

    // asynchronous reset in the middle of BUSY
    issue("ld_rst", LD, 64'h8000, 64'h0);
    check("ld_rst busy dreq_valid", 64'(dreq_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ld_rst async dreq_valid", 64'(dreq_valid), 64'd0);
    check("ld_rst async req_ready", 64'(req_ready), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    check("ld_rst after resp_valid", 64'(resp_valid), 64'd0);

    // final report
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences one data-bus transaction per load/store issued by the memory stage. Latches the request, drives the data bus with size, strobe and shifted write data, and holds the request until the bus returns data. Returns the extended and aligned load result, or a store completion, through a valid/ready handshake. Sits between the memory pipeline stage and the data bus. Uses the team's `databus_pre_align` and `databus_post_align` units for all byte-lane work.

## Interface
Parameters:
- `MISALIGN_CHECK`, default 1: 1 traps accesses whose address is not a multiple of the access size; 0 forwards every access to the bus.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  memory-stage request present
- `req_ready`  out  1  controller can accept a request
- `req_op`  in  instruction_type  one of LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
- `req_addr`  in  64  byte address
- `req_wdata`  in  64  store data, right-justified
- `dreq_valid`  out  1  data-bus request valid
- `dreq_addr`  out  64  latched address
- `dreq_size`  out  msize_t  access size
- `dreq_strobe`  out  8  byte-write strobe; 0 for loads
- `dreq_data`  out  64  lane-shifted store data
- `dresp_addr_ok`  in  1  bus accepted the address (informational)
- `dresp_data_ok`  in  1  bus transaction complete
- `dresp_data`  in  64  raw 64-bit read word
- `resp_valid`  out  1  result available
- `resp_ready`  in  1  memory stage consumes the result
- `resp_rdata`  out  64  extended load result; 0 for stores
- `resp_misaligned`  out  1  access was trapped and did not reach the bus
- `flush`  in  1  discard the current and pending work

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch op, addr and wdata.
  - If misaligned (`MISALIGN_CHECK`=1 and `addr & (bytes-1) != 0`): go to DONE with `misaligned`=1; the bus is untouched.
  - Otherwise go to BUSY.
- BUSY:
  - `dreq_valid`=1. addr, size, strobe and data are driven from latched registers through pre-align and stay constant.
  - `dresp_addr_ok` does not release `dreq_valid`; only `dresp_data_ok` does.
  - On `dresp_data_ok`:
    - Register the post-aligned `dresp_data` into `resp_rdata`; for stores, `resp_rdata`=0.
    - Go to DONE, or to IDLE if killed (see below).
- DONE:
  - `resp_valid`=1 and result registers are held stable.
  - On `resp_ready`, go to IDLE.
- Alignment and extension:
  - Sign-extend for LB, LH, LW; zero-extend for LBU, LHU, LWU; LD passes through.
  - Strobes are 0x01, 0x03, 0x0F, 0xFF, shifted left by `addr[2:0]`.
- Flush:
  - In IDLE: any same-cycle `req_valid` is ignored.
  - In DONE: go to IDLE and suppress the response.
  - In BUSY: the bus transaction is not aborted. Set the kill flag and keep `dreq_valid` until `dresp_data_ok`. Then go directly to IDLE with no `resp_valid`. The kill flag clears on leaving BUSY.
- Invalid `req_op` is never issued; no behaviour is required for it.

## Timing
- Reset (async, `reset`=0): state=IDLE, kill flag=0. All outputs are 0 except `req_ready`=1.
- Acceptance at cycle 0 → `dreq_valid` high from cycle 1.
- `dresp_data_ok` at cycle N≥1 → `dreq_valid` low at N+1, `resp_valid` high at N+1. Best-case load latency is 2 cycles.
- Misaligned request accepted at cycle 0 → `resp_valid`=`resp_misaligned`=1 at cycle 1; `dreq_valid` never rises.
- `resp_valid` stays high until the `resp_ready` cycle. A new request is accepted no earlier than the following cycle, because `req_ready` is high only in IDLE.
- `dresp_addr_ok` and `dresp_data_ok` may arrive in the same cycle; this is treated as completion.
- `flush` together with `dresp_data_ok`: go to IDLE with no response.
- Reset asserted mid-BUSY: drop to IDLE immediately; the bus is expected to be reset with the core.

## Test plan
- LB at addr 0x1003, `dresp_data`=0x0000_0000_80FF_0000 (byte 3 = 0x80), `data_ok` 3 cycles after accept:
  - `dreq_size`=MSIZE1 and `dreq_strobe`=0x00 while busy.
  - `resp_rdata`=0xFFFF_FFFF_FFFF_FF80, `resp_valid` 4 cycles after accept.
- SH at addr 0x2006, `req_wdata`=0xBEEF, `data_ok` the cycle after `dreq_valid` rises:
  - `dreq_strobe`=0xC0, `dreq_data`=0xBEEF_0000_0000_0000.
  - `resp_rdata`=0.
  - `dreq_valid` held constant through 2 stall cycles when `data_ok` is delayed.
- LW at addr 0x3002 with `MISALIGN_CHECK`=1:
  - `resp_misaligned`=1 at cycle 1, `dreq_valid` stays 0.
  - With `MISALIGN_CHECK`=0, the bus is accessed normally.
- LWU at 0x4004, `dresp_data`=0x8000_0001_xxxx_xxxx:
  - `resp_rdata`=0x0000_0000_8000_0001.
  - `resp_ready` held 0 for 3 cycles: `resp_valid` and data stay stable, `req_ready`=0.
- LD issued, `flush` one cycle into BUSY, `data_ok` 2 cycles later:
  - `dreq_valid` held until `data_ok`, `resp_valid` never asserted, `req_ready`=1 the next cycle.
- `reset` dropped asynchronously mid-BUSY:
  - `dreq_valid`=0 and `req_ready`=1 without waiting for a clock edge.
